// File: rtl/cla15_rr_arbiter.sv
// Two-port round-robin front end sharing one 15-bit carry-lookahead add/subtract unit,
// with a single-entry result register drained over a valid/ready handshake.
module cla15_rr_arbiter #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_s,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id
);

    localparam int NBLK = WIDTH / 3;

    logic             res_valid_reg;
    logic [WIDTH-1:0] res_s_reg;
    logic             res_cout_reg;
    logic             res_ovf_reg;
    logic             res_id_reg;
    logic             rr_last_reg;

    logic             slot_free;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_mode;
    logic [WIDTH-1:0] op_bx;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;
    logic [NBLK:0]    blk_c;
    logic [WIDTH-1:0] sum_s;
    logic             sum_ovf;

    // Readies are gated by rst_n so nothing is offered while the block is held in reset.
    always_comb begin
        slot_free = !res_valid_reg || res_ready;
        grant0    = rst_n && slot_free && req0_valid && (!req1_valid || rr_last_reg);
        grant1    = rst_n && slot_free && req1_valid && (!req0_valid || !rr_last_reg);
        op_a      = grant1 ? req1_a    : req0_a;
        op_b      = grant1 ? req1_b    : req0_b;
        op_mode   = grant1 ? req1_mode : req0_mode;
    end

    assign op_bx    = op_mode ? ~op_b : op_b;
    assign gen      = op_a & op_bx;
    assign prop     = op_a ^ op_bx;
    assign blk_c[0] = op_mode;

    // Five 3-bit lookahead groups; group carries chain through group generate/propagate.
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        localparam int BASE = 3 * gi;
        logic [2:0] gg;
        logic [2:0] pp;
        logic       blk_g;
        logic       blk_p;

        assign gg = gen[BASE +: 3];
        assign pp = prop[BASE +: 3];

        assign carry[BASE]     = blk_c[gi];
        assign carry[BASE + 1] = gg[0] | (pp[0] & blk_c[gi]);
        assign carry[BASE + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & blk_c[gi]);

        assign blk_g         = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]);
        assign blk_p         = &pp;
        assign blk_c[gi + 1] = blk_g | (blk_p & blk_c[gi]);
    end

    assign sum_s   = prop ^ carry;
    assign sum_ovf = (op_a[WIDTH-1] == op_bx[WIDTH-1]) && (sum_s[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_reg <= 1'b0;
            res_s_reg     <= '0;
            res_cout_reg  <= 1'b0;
            res_ovf_reg   <= 1'b0;
            res_id_reg    <= 1'b0;
            rr_last_reg   <= 1'b1;
        end else if (grant0 || grant1) begin
            res_valid_reg <= 1'b1;
            res_s_reg     <= sum_s;
            res_cout_reg  <= blk_c[NBLK];
            res_ovf_reg   <= sum_ovf;
            res_id_reg    <= grant1;
            rr_last_reg   <= grant1;
        end else if (res_ready) begin
            // Drain without refill: payload fields keep their last values.
            res_valid_reg <= 1'b0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res_valid  = res_valid_reg;
    assign res_s      = res_s_reg;
    assign res_cout   = res_cout_reg;
    assign res_ovf    = res_ovf_reg;
    assign res_id     = res_id_reg;

endmodule

// File: tb/tb_cla15_rr_arbiter.sv
// Directed bench for cla15_rr_arbiter: vector table for single transfers plus
// hand-written fairness, backpressure and mid-operation reset sequences.
module tb_cla15_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_mode;
    logic [14:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_mode;
    logic [14:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_cout, res_ovf, res_id;
    logic [14:0] res_s;

    int tests = 0;
    int fails = 0;
    int n0 = 0;
    int n1 = 0;

    typedef struct {
        logic        v0;
        logic [14:0] a0, b0;
        logic        m0;
        logic        v1;
        logic [14:0] a1, b1;
        logic        m1;
        logic        rdy;
        logic        er0, er1, ev;
        logic [14:0] es;
        logic        ec, eo, eid;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    cla15_rr_arbiter #(.WIDTH(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s),
        .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Returns {ovf, cout, s[14:0]}.
    function automatic logic [16:0] model(input logic [14:0] a, input logic [14:0] b, input logic m);
        logic [14:0] bx;
        logic [15:0] t;
        logic        o;
        bx = m ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + {15'b0, m};
        o  = (a[14] == bx[14]) && (t[14] != a[14]);
        return {o, t};
    endfunction

    task automatic chk_res(input string tag, input logic [16:0] e, input logic eid);
        chk({tag, ".valid"}, res_valid, 1'b1);
        chk({tag, ".s"},     res_s,     e[14:0]);
        chk({tag, ".cout"},  res_cout,  e[15]);
        chk({tag, ".ovf"},   res_ovf,   e[16]);
        chk({tag, ".id"},    res_id,    eid);
        $display("[TB] %s id=%0d s=0x%04h cout=%0d ovf=%0d", tag, res_id, res_s, res_cout, res_ovf);
    endtask

    task automatic drive_ops();
        logic [31:0] t;
        t = 32'h0100 + 32'(n0) * 32'h0111;  req0_a = t[14:0];
        t = 32'(n0) * 32'd3;                req0_b = t[14:0];
        req0_mode = 1'b0;
        t = 32'h4000 + 32'(n1) * 32'h0123;  req1_a = t[14:0];
        t = 32'h0155 * 32'(n1 + 1);         req1_b = t[14:0];
        req1_mode = 1'b1;
    endtask

    initial begin
        logic [16:0] e;
        logic        eid;

        //           v0    a0        b0        m0    v1    a1        b1        m1    rdy   er0   er1   ev    es        ec    eo    eid
        vecs[0] = '{1'b1, 15'h0004, 15'h0002, 1'b0, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h0006, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 15'h2000, 15'h2000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 15'h4000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 15'h6000, 15'h6000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 15'h4000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 15'h2000, 15'h6000, 1'b1, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h4000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 15'h4000, 15'h3FFF, 1'b1, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h0001, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 15'h0000, 15'h0000, 1'b0, 1'b0, 15'h0000, 15'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0001, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 15'h0005, 15'h0003, 1'b0, 1'b1, 15'h7FFF, 15'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0000, 1'b1, 1'b0, 1'b1};

        // Reset state, with valids high to confirm readies stay low in reset.
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_mode = 1'b0;
        req1_a = '0; req1_b = '0; req1_mode = 1'b0;
        #3;
        chk("rst.valid", res_valid, 1'b0);
        chk("rst.s", res_s, 15'h0);
        chk("rst.cout", res_cout, 1'b0);
        chk("rst.ovf", res_ovf, 1'b0);
        chk("rst.id", res_id, 1'b0);
        chk("rst.ready0", req0_ready, 1'b0);
        chk("rst.ready1", req1_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_mode = vecs[i].m0;
            req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_mode = vecs[i].m1;
            res_ready  = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d.ready0", i), req0_ready, vecs[i].er0);
            chk($sformatf("vec%0d.ready1", i), req1_ready, vecs[i].er1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.valid", i), res_valid, vecs[i].ev);
            chk($sformatf("vec%0d.s", i),     res_s,     vecs[i].es);
            chk($sformatf("vec%0d.cout", i),  res_cout,  vecs[i].ec);
            chk($sformatf("vec%0d.ovf", i),   res_ovf,   vecs[i].eo);
            chk($sformatf("vec%0d.id", i),    res_id,    vecs[i].eid);
            $display("[TB] vec%0d valid=%0d id=%0d s=0x%04h cout=%0d ovf=%0d",
                     i, res_valid, res_id, res_s, res_cout, res_ovf);
        end

        // Continuous contention: strict alternation starting at port 0.
        e = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_ops();
            req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
            eid = (i % 2 == 1);
            e = eid ? model(req1_a, req1_b, req1_mode) : model(req0_a, req0_b, req0_mode);
            #1;
            chk($sformatf("fair%0d.ready0", i), req0_ready, !eid);
            chk($sformatf("fair%0d.ready1", i), req1_ready, eid);
            @(posedge clk);
            #1;
            chk_res($sformatf("fair%0d", i), e, eid);
            if (eid) n1++; else n0++;
        end

        // Backpressure: both pending, consumer stalled for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_ops();
            res_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d.ready0", i), req0_ready, 1'b0);
            chk($sformatf("bp%0d.ready1", i), req1_ready, 1'b0);
            @(posedge clk);
            #1;
            chk_res($sformatf("bp%0d", i), e, 1'b1);
        end

        // Release: port 0 (not last served) first, then port 1's held operation.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_ops();
            res_ready = 1'b1;
            eid = (i == 1);
            e = eid ? model(req1_a, req1_b, req1_mode) : model(req0_a, req0_b, req0_mode);
            #1;
            chk($sformatf("rel%0d.ready0", i), req0_ready, !eid);
            chk($sformatf("rel%0d.ready1", i), req1_ready, eid);
            @(posedge clk);
            #1;
            chk_res($sformatf("rel%0d", i), e, eid);
            if (eid) n1++; else n0++;
        end

        // Reset while a result is held and both requesters are waiting.
        @(negedge clk);
        drive_ops();
        res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", res_valid, 1'b0);
        chk("mrst.s", res_s, 15'h0);
        chk("mrst.id", res_id, 1'b0);
        chk("mrst.ready0", req0_ready, 1'b0);
        chk("mrst.ready1", req1_ready, 1'b0);
        $display("[TB] mrst valid=%0d ready0=%0d ready1=%0d", res_valid, req0_ready, req1_ready);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        e = model(req0_a, req0_b, req0_mode);
        #1;
        chk("post.ready0", req0_ready, 1'b1);
        chk("post.ready1", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk_res("post", e, 1'b0);

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain.valid", res_valid, 1'b0);
        chk("drain.s", res_s, e[14:0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla15_rr_arbiter.md
Name: cla15_rr_arbiter

Overview:
- Shares one 15-bit carry-lookahead add/subtract datapath between two requesters.
- Each requester presents operands A, B and a mode bit over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle, performs the add/subtract, and captures the result, Cout, Ovf and requester ID in a single-entry output register.
- The output register drains to a downstream consumer over a valid/ready handshake.

Parameters:
- WIDTH, 15, operand/result width. Fixed at 15; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  15  requester 0 operand A.
- req0_b  input  15  requester 0 operand B.
- req0_mode  input  1  requester 0 mode: 0 = A+B, 1 = A-B.
- req1_valid, req1_ready, req1_a, req1_b, req1_mode: same as requester 0, for requester 1.
- res_valid  output  1  result register holds a valid result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_s  output  15  sum/difference.
- res_cout  output  1  carry out of bit 14.
- res_ovf  output  1  two's-complement signed overflow.
- res_id  output  1  requester that produced the result.

Behaviour:
- Reset (async assert, sync release): res_valid=0, res_s=0, res_cout=0, res_ovf=0, res_id=0, rr_last=1 (port 0 has priority first). req0_ready and req1_ready are 0 while rst_n=0.
- slot_free = !res_valid | res_ready (combinational).
- Grant:
  - only one reqN_valid asserted -> grant that port;
  - both asserted -> grant the port != rr_last;
  - no grant when slot_free=0.
- reqN_ready = grantN. Each ready depends combinationally on both valids, res_valid and res_ready. Ready never depends on itself; no combinational loop.
- Transfer occurs when reqN_valid & reqN_ready. At that edge:
  - result register loads the granted port's operation;
  - res_id <= N, rr_last <= N, res_valid <= 1.
- Arithmetic, with Bx = mode ? ~B : B and cin = mode:
  - {res_cout, res_s} = A + Bx + cin (16-bit intermediate).
  - res_ovf = (A[14] == Bx[14]) & (res_s[14] != A[14]).
  - Results match the combinational CLA add/sub unit bit-for-bit.
- Latency: one cycle. An operation accepted at edge k is visible on res_* after edge k.
- Throughput: one operation per cycle while res_ready=1.
- Drain without refill: res_valid & res_ready & no grant -> res_valid <= 0 at the edge. res_s, res_cout, res_ovf and res_id hold their last values.
- Simultaneous drain and accept: new result loads in the same edge; res_valid stays 1 with no bubble.
- Backpressure: while res_valid=1 and res_ready=0:
  - res_* stay stable;
  - both readies are 0;
  - rr_last is unchanged.
- Requester rules:
  - A requester holds valid and its operands/mode stable until accepted.
  - The block samples operands only on the transfer edge.
- Fairness: under continuous contention with res_ready=1, grants strictly alternate 0,1,0,1. Neither port waits more than one accepted operation.
- Reset mid-operation: the pending result is discarded (res_valid=0) and the arbiter returns to port-0 priority. No partial result appears after reset release.

Test Plan:
- Reset, then req0 A=4, B=2, mode=0, res_ready=1 -> one cycle later res_valid=1, res_s=6, res_cout=0, res_ovf=0, res_id=0.
- req1 A=0x2000, B=0x2000, mode=0 -> res_s=0x4000, res_cout=0, res_ovf=1, res_id=1. Then A=0x6000, B=0x6000, mode=0 -> res_s=0x4000, res_cout=1, res_ovf=0.
- Subtraction via req0 mode=1:
  - A=0x2000, B=0x6000 -> res_s=0x4000, res_cout=0, res_ovf=1;
  - A=0x4000, B=0x3FFF -> res_s=0x0001, res_cout=1, res_ovf=1.
- Both valid for 6 cycles, res_ready=1, distinct operands -> res_id sequence 0,1,0,1,0,1 with each result matching its requester's operands; no cycle with res_valid=0 after the first.
- res_ready=0 for 4 cycles with both requesters valid -> both readies 0, res_* frozen. Release res_ready -> next grant goes to the port not last served; no operation lost or duplicated.
- Assert rst_n=0 while res_valid=1 and both valid -> res_valid drops immediately without a clock. After release, first grant goes to port 0.
